i2c_pcf8574_target: RTL and testbench

I2C target (responder) emulating a PCF8574 8-bit I/O expander, the device that sits behind the hd44780 LCD backpack. It decodes the bus driven by our I2C master. Written bytes appear on port_out, which can feed an HD44780 model or LEDs. Reads return port_in. Used for on-board loopback of the LCD driver and as a simulation model in lcdtest benches.

---
 rtl/i2c_pcf8574_target.sv | 142 ++++++++++++++
 tb/tb_i2c_pcf8574_target.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_pcf8574_target.sv
// i2c_pcf8574_target: PCF8574-style I2C target; written bytes appear on port_out, reads return port_in.
module i2c_pcf8574_target #(
  parameter logic [6:0] ADDR      = 7'h27,
  parameter logic [7:0] RESET_VAL = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] port_out,
  input  logic [7:0] port_in,
  output logic       wr_strobe,
  output logic       rd_strobe,
  output logic       busy
);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ADDR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE} state_t;
  state_t     r_state, w_state_nx;
  logic [2:0] r_scl, r_sda;
  logic [3:0] r_cnt, w_cnt_nx;
  logic [7:0] r_sr, w_sr_nx, r_port, w_port_nx;
  logic       r_oe, w_oe_nx, r_wr, w_wr_nx, r_rd, w_rd_nx, r_busy, w_busy_nx;
  logic       w_rise, w_fall, w_start, w_stop, w_sda, w_full, w_match;

  // bit 1 is the synchronized level, bit 2 its one-cycle history
  assign w_sda   = r_sda[1];
  assign w_rise  = r_scl[1] & ~r_scl[2];
  assign w_fall  = ~r_scl[1] & r_scl[2];
  assign w_start = r_scl[1] & r_scl[2] & r_sda[2] & ~r_sda[1];
  assign w_stop  = r_scl[1] & r_scl[2] & ~r_sda[2] & r_sda[1];
  assign w_full  = r_cnt == 4'd8;
  assign w_match = r_sr[7:1] == ADDR;

  assign sda_oe    = r_oe;
  assign port_out  = r_port;
  assign wr_strobe = r_wr;
  assign rd_strobe = r_rd;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nx;

  always_comb begin
    w_state_nx = r_state;
    if (w_start) w_state_nx = S_ADDR;
    else if (w_stop) w_state_nx = S_IDLE;
    else
      case (r_state)
        S_ADDR:     if (w_fall && w_full) w_state_nx = w_match ? S_ADDR_ACK : S_IGNORE;
        S_ADDR_ACK: if (w_fall) w_state_nx = r_sr[0] ? S_RD : S_WR;
        S_WR:       if (w_fall && w_full) w_state_nx = S_WR_ACK;
        S_WR_ACK:   if (w_fall) w_state_nx = S_WR;
        S_RD:       if (w_fall && w_full) w_state_nx = S_RD_ACK;
        S_RD_ACK:   if (w_rise && w_sda) w_state_nx = S_IGNORE;
                    else if (w_fall && r_cnt == 4'd1) w_state_nx = S_RD;
        default:    ;
      endcase
  end

  always_comb begin
    w_oe_nx   = r_oe;
    w_cnt_nx  = r_cnt;
    w_sr_nx   = r_sr;
    w_port_nx = r_port;
    w_busy_nx = r_busy;
    w_wr_nx   = 1'b0;
    w_rd_nx   = 1'b0;
    if (w_start || w_stop) begin
      w_oe_nx   = 1'b0;
      w_cnt_nx  = 4'd0;
      w_busy_nx = 1'b0;
    end else
      case (r_state)
        S_ADDR, S_WR:
          if (w_rise) begin
            w_sr_nx  = {r_sr[6:0], w_sda};
            w_cnt_nx = r_cnt + 4'd1;
          end else if (w_fall && w_full) begin
            w_cnt_nx = 4'd0;
            w_oe_nx  = (r_state == S_WR) | w_match;
          end
        S_ADDR_ACK:
          if (w_fall) begin
            w_busy_nx = 1'b1;
            w_cnt_nx  = 4'd0;
            w_sr_nx   = r_sr[0] ? port_in : r_sr;
            w_rd_nx   = r_sr[0];
            w_oe_nx   = r_sr[0] & ~port_in[7];
          end
        S_WR_ACK:
          if (w_fall) begin
            w_oe_nx   = 1'b0;
            w_port_nx = r_sr;
            w_wr_nx   = 1'b1;
            w_cnt_nx  = 4'd0;
          end
        S_RD:
          if (w_rise) w_cnt_nx = r_cnt + 4'd1;
          else if (w_fall) begin
            w_cnt_nx = w_full ? 4'd0 : r_cnt;
            w_sr_nx  = w_full ? r_sr : {r_sr[6:0], 1'b0};
            w_oe_nx  = ~w_full & ~r_sr[6];
          end
        // cnt=1 marks a master ACK seen on the ninth rise
        S_RD_ACK:
          if (w_rise) begin
            w_busy_nx = ~w_sda;
            w_cnt_nx  = w_sda ? 4'd0 : 4'd1;
          end else if (w_fall && r_cnt == 4'd1) begin
            w_sr_nx  = port_in;
            w_rd_nx  = 1'b1;
            w_oe_nx  = ~port_in[7];
            w_cnt_nx = 4'd0;
          end
        default: w_oe_nx = 1'b0;
      endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_scl  <= 3'b111;
      r_sda  <= 3'b111;
      r_oe   <= 1'b0;
      r_cnt  <= 4'd0;
      r_sr   <= 8'd0;
      r_port <= RESET_VAL;
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_scl  <= {r_scl[1:0], scl_in};
      r_sda  <= {r_sda[1:0], sda_in};
      r_oe   <= w_oe_nx;
      r_cnt  <= w_cnt_nx;
      r_sr   <= w_sr_nx;
      r_port <= w_port_nx;
      r_wr   <= w_wr_nx;
      r_rd   <= w_rd_nx;
      r_busy <= w_busy_nx;
    end
endmodule

// File: tb/tb_i2c_pcf8574_target.sv
// tb_i2c_pcf8574_target: bit-slot level I2C master with a protocol-rule model of the target.
module tb_i2c_pcf8574_target;
  localparam logic [6:0] A = 7'h27;
  localparam int Q = 6;
  logic clk = 0, rst_n = 0, scl_m = 1, sda_m = 1;
  logic [7:0] port_in = 8'h00;
  logic sda_oe, wr_strobe, rd_strobe, busy, sda_line;
  logic [7:0] port_out;
  int checks = 0, errors = 0, n_wr = 0, n_rd = 0, exp_wr = 0, exp_rd = 0;
  logic exp_oe = 0, exp_busy = 0, chk_busy = 0, chk_en = 0;
  logic [7:0] exp_port = 8'hFF;

  assign sda_line = sda_m & ~sda_oe;
  always #5 clk = ~clk;

  i2c_pcf8574_target dut (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_m), .sda_in(sda_line), .sda_oe(sda_oe),
    .port_out(port_out), .port_in(port_in), .wr_strobe(wr_strobe), .rd_strobe(rd_strobe), .busy(busy)
  );

  // Continuous compare against the model while SCL is stably high inside a bit slot
  always @(negedge clk) begin
    if (wr_strobe) n_wr++;
    if (rd_strobe) n_rd++;
    if (chk_en) begin
      checks++;
      if (sda_oe !== exp_oe) begin errors++; $display("FAIL slot_oe t=%0t got %b want %b", $time, sda_oe, exp_oe); end
      checks++;
      if (port_out !== exp_port) begin errors++; $display("FAIL slot_port t=%0t got %h want %h", $time, port_out, exp_port); end
      if (chk_busy) begin
        checks++;
        if (busy !== exp_busy) begin errors++; $display("FAIL slot_busy t=%0t got %b want %b", $time, busy, exp_busy); end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin errors++; $display("FAIL %s got %0h want %0h", name, got, want); end
  endtask

  task automatic bit_slot(input logic b, input logic eo, input logic eb, input logic cb, output logic rx);
    sda_m = b;
    tick(Q);
    exp_oe = eo; exp_busy = eb; chk_busy = cb;
    scl_m = 1;
    tick(5);
    chk_en = 1;
    tick(8);
    rx = sda_line;
    chk_en = 0;
    tick(4);
    scl_m = 0;
    tick(Q);
  endtask

  task automatic start_c();
    sda_m = 1; tick(Q);
    scl_m = 1; tick(Q);
    sda_m = 0; tick(Q);
    scl_m = 0; tick(Q);
  endtask

  task automatic stop_c();
    sda_m = 0; tick(Q);
    scl_m = 1; tick(Q);
    sda_m = 1; tick(Q);
    chk("stop_oe", sda_oe, 0);
    chk("stop_busy", busy, 0);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic eb, input logic eack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_slot(d[i], 1'b0, eb, 1'b1, r);
    bit_slot(1'b1, eack, eb, 1'b1, r);
  endtask

  task automatic rd_byte(input logic nack, input logic [7:0] nxt, output logic [7:0] got);
    logic [7:0] e;
    logic r;
    e = port_in;
    for (int i = 7; i >= 0; i--) begin
      bit_slot(1'b1, ~e[i], 1'b1, 1'b1, r);
      got[i] = r;
    end
    chk("rd_byte", got, e);
    port_in = nxt;
    bit_slot(nack, 1'b0, 1'b1, 1'b0, r);
    if (!nack) exp_rd++;
  endtask

  task automatic chk_counts();
    chk("wr_count", n_wr, exp_wr);
    chk("rd_count", n_rd, exp_rd);
  endtask

  initial begin
    logic [7:0] g1, g2, d;
    logic [6:0] a;
    logic rw, hit, r;
    int nb;
    tick(3);
    chk("rst_oe", sda_oe, 0);
    chk("rst_port", port_out, 8'hFF);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {wr_strobe, rd_strobe}, 0);
    rst_n = 1;
    tick(4);

    // foreign address 0x3F: never driven, nothing written
    start_c(); wr_byte(8'h7E, 0, 0); wr_byte(8'h55, 0, 0); stop_c();
    chk("t2_port", port_out, 8'hFF);
    chk_counts();

    // single write 0x0C
    start_c(); wr_byte(8'h4E, 0, 1); wr_byte(8'h0C, 1, 1);
    exp_port = 8'h0C; exp_wr++;
    stop_c();
    chk("t1_port", port_out, 8'h0C);
    chk_counts();

    // read A5 (ACK) then 3C (NACK)
    port_in = 8'hA5;
    start_c(); wr_byte(8'h4F, 0, 1); exp_rd++;
    rd_byte(0, 8'h3C, g1);
    rd_byte(1, 8'h00, g2);
    chk("t3_b1", g1, 8'hA5);
    chk("t3_b2", g2, 8'h3C);
    chk("t3_released", sda_oe, 0);
    stop_c();
    chk("t3_rd_strobes", n_rd, 2);
    chk_counts();

    // repeated start between two writes
    start_c(); wr_byte(8'h4E, 0, 1); wr_byte(8'h12, 1, 1);
    exp_port = 8'h12; exp_wr++;
    tick(2);
    chk("t4_first", port_out, 8'h12);
    start_c(); wr_byte(8'h4E, 0, 1); wr_byte(8'h34, 1, 1);
    exp_port = 8'h34; exp_wr++;
    stop_c();
    chk("t4_second", port_out, 8'h34);
    chk_counts();

    // aborted byte leaves port_out alone
    start_c(); wr_byte(8'h4E, 0, 1);
    for (int i = 0; i < 4; i++) bit_slot(1'b1, 1'b0, 1'b1, 1'b1, r);
    stop_c();
    chk("t6_port", port_out, 8'h34);
    chk_counts();

    // reset in the middle of a write ACK
    start_c(); wr_byte(8'h4E, 0, 1);
    for (int i = 7; i >= 0; i--) bit_slot(i[0], 1'b0, 1'b1, 1'b1, r);
    sda_m = 1; tick(Q);
    scl_m = 1; tick(5);
    chk("t5_ack_drive", sda_oe, 1);
    rst_n = 0;
    #1;
    chk("t5_async_oe", sda_oe, 0);
    chk("t5_port", port_out, 8'hFF);
    exp_port = 8'hFF;
    tick(3);
    rst_n = 1;
    tick(2);
    scl_m = 0;
    tick(Q);
    start_c(); wr_byte(8'h4E, 0, 1); wr_byte(8'h5A, 1, 1);
    exp_port = 8'h5A; exp_wr++;
    stop_c();
    chk("t5_after", port_out, 8'h5A);
    chk_counts();

    // randomized transactions
    for (int t = 0; t < 25; t++) begin
      a = ($urandom_range(0, 3) != 0) ? A : 7'($urandom_range(0, 127));
      hit = (a == A);
      rw = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      if (rw) port_in = 8'($urandom);
      start_c();
      wr_byte({a, rw}, 0, hit);
      if (hit && rw) begin
        exp_rd++;
        for (int k = 0; k < nb; k++) rd_byte(k == nb - 1, 8'($urandom), g1);
      end else
        for (int k = 0; k < nb; k++) begin
          d = 8'($urandom);
          wr_byte(d, hit, hit);
          if (hit) begin exp_port = d; exp_wr++; end
        end
      if ($urandom_range(0, 1) != 0) stop_c();
      chk_counts();
    end
    stop_c();
    chk("final_port", port_out, exp_port);
    chk_counts();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
